// File: rtl/carfield_pkg.sv
// Shared carfield definitions: mailbox placement, register offsets and STATUS layout.
package carfield_pkg;

  localparam logic [31:0] OTMailboxBase = 32'h4000_0000;
  localparam logic [31:0] OTMailboxSize = 32'h0000_1000;

  typedef enum logic [4:0] {
    MboxTxData  = 5'h00,
    MboxRxData  = 5'h04,
    MboxStatus  = 5'h08,
    MboxIrqEn   = 5'h0C,
    MboxIrqPend = 5'h10
  } mbox_reg_e;

  localparam int unsigned StatusTxFull   = 0;
  localparam int unsigned StatusTxEmpty  = 1;
  localparam int unsigned StatusRxFull   = 2;
  localparam int unsigned StatusRxEmpty  = 3;
  localparam int unsigned StatusTxCntLsb = 4;
  localparam int unsigned StatusRxCntLsb = 9;
  localparam int unsigned StatusCntWidth = 5;

endpackage

// File: rtl/fifo_v3.sv
// Synchronous FIFO with registered occupancy count; optional fall-through when empty.
module fifo_v3 #(
  parameter bit          FALL_THROUGH = 1'b0,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH        = 8,
  localparam int unsigned AddrDepth   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [AddrDepth:0]    usage_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  push_i,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  pop_i
);

  typedef logic [AddrDepth-1:0] ptr_t;
  typedef logic [AddrDepth:0]   cnt_t;

  ptr_t rdPtrReg, wrPtrReg;
  cnt_t cntReg;
  logic bypass, storePush, storePop;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  assign full_o  = (cntReg == cnt_t'(DEPTH));
  assign empty_o = (cntReg == '0);
  assign usage_o = cntReg;

  // In fall-through mode a word pushed and popped while empty never touches storage.
  assign bypass    = FALL_THROUGH && empty_o && push_i && pop_i;
  assign storePush = push_i && !full_o && !bypass;
  assign storePop  = pop_i && !empty_o;
  assign data_o    = (FALL_THROUGH && empty_o) ? data_i : mem[rdPtrReg];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdPtrReg <= '0;
      wrPtrReg <= '0;
      cntReg   <= '0;
    end else if (flush_i) begin
      rdPtrReg <= '0;
      wrPtrReg <= '0;
      cntReg   <= '0;
    end else begin
      if (storePush) wrPtrReg <= wrPtrReg + ptr_t'(1);
      if (storePop)  rdPtrReg <= rdPtrReg + ptr_t'(1);
      if (storePush && !storePop)      cntReg <= cntReg + cnt_t'(1);
      else if (!storePush && storePop) cntReg <= cntReg - cnt_t'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (storePush) mem[wrPtrReg] <= data_i;
  end

endmodule

// File: rtl/carfield_mbox.sv
// Host <-> security-island mailbox: register front end, one FIFO per direction, RX interrupt.
module carfield_mbox
  import carfield_pkg::*;
#(
  parameter int unsigned Depth     = 4,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned AddrWidth = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   reg_valid_i,
  input  logic                   reg_write_i,
  input  logic [AddrWidth-1:0]   reg_addr_i,
  input  logic [DataWidth-1:0]   reg_wdata_i,
  input  logic [DataWidth/8-1:0] reg_wstrb_i,
  output logic                   reg_ready_o,
  output logic                   reg_error_o,
  output logic [DataWidth-1:0]   reg_rdata_o,
  output logic                   tx_valid_o,
  output logic [DataWidth-1:0]   tx_data_o,
  input  logic                   tx_ready_i,
  input  logic                   rx_valid_i,
  input  logic [DataWidth-1:0]   rx_data_i,
  output logic                   rx_ready_o,
  output logic                   irq_o
);

  localparam int unsigned CntWidth = $clog2(Depth) + 1;

  logic txFull, txEmpty, rxFull, rxEmpty;
  logic [CntWidth-1:0] txCnt, rxCnt;
  logic [DataWidth-1:0] rxHead, statusWord, regRdata;
  logic txPush, txPop, rxPush, rxPop;
  logic regError, irqEnWe, irqPendClr;
  logic irqEnReg, irqPendReg, irqReg;
  logic [4:0] regOff;
  logic unusedBits;

  assign unusedBits = ^{reg_addr_i[AddrWidth-1:5], reg_wstrb_i[DataWidth/8-1:1]};

  fifo_v3 #(.FALL_THROUGH(1'b0), .DATA_WIDTH(DataWidth), .DEPTH(Depth)) iTxFifo (
    .clk_i, .rst_ni, .flush_i(1'b0),
    .full_o(txFull), .empty_o(txEmpty), .usage_o(txCnt),
    .data_i(reg_wdata_i), .push_i(txPush), .data_o(tx_data_o), .pop_i(txPop)
  );

  fifo_v3 #(.FALL_THROUGH(1'b0), .DATA_WIDTH(DataWidth), .DEPTH(Depth)) iRxFifo (
    .clk_i, .rst_ni, .flush_i(1'b0),
    .full_o(rxFull), .empty_o(rxEmpty), .usage_o(rxCnt),
    .data_i(rx_data_i), .push_i(rxPush), .data_o(rxHead), .pop_i(rxPop)
  );

  assign tx_valid_o = !txEmpty;
  assign txPop      = tx_valid_o && tx_ready_i;
  assign rx_ready_o = !rxFull;
  assign rxPush     = rx_valid_i && rx_ready_o;

  always_comb begin
    statusWord = '0;
    statusWord[StatusTxFull]  = txFull;
    statusWord[StatusTxEmpty] = txEmpty;
    statusWord[StatusRxFull]  = rxFull;
    statusWord[StatusRxEmpty] = rxEmpty;
    statusWord[StatusTxCntLsb +: StatusCntWidth] = StatusCntWidth'(txCnt);
    statusWord[StatusRxCntLsb +: StatusCntWidth] = StatusCntWidth'(rxCnt);
  end

  assign regOff = reg_addr_i[4:0];

  // Every error path leaves rdata at zero and raises no FIFO or IRQ strobe.
  always_comb begin
    regRdata   = '0;
    regError   = 1'b0;
    txPush     = 1'b0;
    rxPop      = 1'b0;
    irqEnWe    = 1'b0;
    irqPendClr = 1'b0;
    if (reg_valid_i) begin
      case (regOff)
        MboxTxData: begin
          if (!reg_write_i || txFull) regError = 1'b1;
          else                         txPush   = 1'b1;
        end
        MboxRxData: begin
          if (reg_write_i || rxEmpty) regError = 1'b1;
          else begin
            regRdata = rxHead;
            rxPop    = 1'b1;
          end
        end
        MboxStatus: begin
          if (reg_write_i) regError = 1'b1;
          else             regRdata = statusWord;
        end
        MboxIrqEn: begin
          if (reg_write_i) irqEnWe     = reg_wstrb_i[0];
          else             regRdata[0] = irqEnReg;
        end
        MboxIrqPend: begin
          if (reg_write_i) irqPendClr  = reg_wstrb_i[0] && reg_wdata_i[0];
          else             regRdata[0] = irqPendReg;
        end
        default: regError = 1'b1;
      endcase
    end
  end

  assign reg_ready_o = 1'b1;
  assign reg_error_o = regError;
  assign reg_rdata_o = rst_ni ? regRdata : '0;

  // A new RX word wins over a simultaneous W1C so no message goes unsignalled.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      irqEnReg   <= 1'b0;
      irqPendReg <= 1'b0;
      irqReg     <= 1'b0;
    end else begin
      if (irqEnWe) irqEnReg <= reg_wdata_i[0];
      if (rxPush)          irqPendReg <= 1'b1;
      else if (irqPendClr) irqPendReg <= 1'b0;
      irqReg <= irqEnReg && irqPendReg;
    end
  end

  assign irq_o = irqReg;

endmodule

// File: tb/tb_carfield_mbox.sv
// Scoreboard bench for carfield_mbox: register and TX-stream responses are queued at issue time.
module tb_carfield_mbox;
  import carfield_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        reg_valid_i, reg_write_i;
  logic [31:0] reg_addr_i, reg_wdata_i;
  logic [3:0]  reg_wstrb_i;
  logic        reg_ready_o, reg_error_o;
  logic [31:0] reg_rdata_o;
  logic        tx_valid_o, tx_ready_i;
  logic [31:0] tx_data_o;
  logic        rx_valid_i, rx_ready_o, irq_o;
  logic [31:0] rx_data_i;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic        err;
    logic [31:0] rdata;
  } reg_exp_t;

  reg_exp_t    regQ[$];
  logic [31:0] txQ[$];
  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  carfield_mbox #(.Depth(4), .DataWidth(32), .AddrWidth(32)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .reg_valid_i(reg_valid_i), .reg_write_i(reg_write_i), .reg_addr_i(reg_addr_i),
    .reg_wdata_i(reg_wdata_i), .reg_wstrb_i(reg_wstrb_i),
    .reg_ready_o(reg_ready_o), .reg_error_o(reg_error_o), .reg_rdata_o(reg_rdata_o),
    .tx_valid_o(tx_valid_o), .tx_data_o(tx_data_o), .tx_ready_i(tx_ready_i),
    .rx_valid_i(rx_valid_i), .rx_data_i(rx_data_i), .rx_ready_o(rx_ready_o),
    .irq_o(irq_o)
  );

  // Monitor: compares every register access and every TX handshake against the queues.
  always @(negedge clk_i) begin
    if (rst_ni === 1'b1 && reg_valid_i) begin
      checks++;
      if (regQ.size() == 0) begin
        errors++;
        $display("FAIL reg_unexpected addr=%h got err=%0b rdata=%h required none", reg_addr_i, reg_error_o, reg_rdata_o);
      end else begin
        reg_exp_t e;
        e = regQ.pop_front();
        if (reg_error_o !== e.err || reg_rdata_o !== e.rdata || reg_ready_o !== 1'b1) begin
          errors++;
          $display("FAIL reg_%s addr=%h got err=%0b rdata=%h required err=%0b rdata=%h",
                   e.wr ? "wr" : "rd", e.addr, reg_error_o, reg_rdata_o, e.err, e.rdata);
        end else
          $display("reg %s addr=%h err=%0b rdata=%h ok", e.wr ? "wr" : "rd", e.addr, reg_error_o, reg_rdata_o);
      end
    end
    if (rst_ni === 1'b1 && tx_valid_o && tx_ready_i) begin
      checks++;
      if (txQ.size() == 0) begin
        errors++;
        $display("FAIL tx_unexpected got data=%h required none", tx_data_o);
      end else begin
        logic [31:0] d;
        d = txQ.pop_front();
        if (tx_data_o !== d) begin
          errors++;
          $display("FAIL tx_data got %h required %h", tx_data_o, d);
        end else
          $display("tx data=%h ok", tx_data_o);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h required %h", name, act, exp);
    end else
      $display("level %s = %h ok", name, act);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  // Called at posedge+1; the access is applied at the next edge.
  task automatic regAcc(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, input logic expErr, input logic [31:0] expRdata);
    regQ.push_back('{wr: wr, addr: addr, err: expErr, rdata: expRdata});
    reg_valid_i = 1'b1;
    reg_write_i = wr;
    reg_addr_i  = addr;
    reg_wdata_i = wdata;
    reg_wstrb_i = strb;
    tick(1);
    reg_valid_i = 1'b0;
    reg_write_i = 1'b0;
  endtask

  task automatic rxPushWord(input logic [31:0] d);
    rx_valid_i = 1'b1;
    rx_data_i  = d;
    tick(1);
    rx_valid_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni = 1'b0;
    reg_valid_i = 0; reg_write_i = 0; reg_addr_i = 0; reg_wdata_i = 0; reg_wstrb_i = 0;
    tx_ready_i = 0; rx_valid_i = 0; rx_data_i = 0;
    tick(2);
    reg_valid_i = 1'b1; reg_addr_i = 32'h08;
    #1;
    chk("rst_rdata", reg_rdata_o, 32'h0);
    chk("rst_tx_valid", {31'h0, tx_valid_o}, 32'h0);
    chk("rst_rx_ready", {31'h0, rx_ready_o}, 32'h1);
    chk("rst_irq", {31'h0, irq_o}, 32'h0);
    reg_valid_i = 1'b0;
    tick(1);
    rst_ni = 1'b1;
    tick(1);

    regAcc(0, 32'h08, 0, 0, 0, 32'h0000_000A);

    // Two TX words held back, then drained in order
    regAcc(1, 32'h00, 32'hCAFE0001, 4'hF, 0, 0);
    regAcc(1, 32'h00, 32'hCAFE0002, 4'h0, 0, 0);
    txQ.push_back(32'hCAFE0001);
    txQ.push_back(32'hCAFE0002);
    regAcc(0, OTMailboxBase | 32'h08, 0, 0, 0, 32'h0000_0028);
    tick(2);
    chk("tx_hold_valid", {31'h0, tx_valid_o}, 32'h1);
    chk("tx_hold_data", tx_data_o, 32'hCAFE0001);
    tx_ready_i = 1'b1;
    tick(4);
    tx_ready_i = 1'b0;
    chk("tx_drained_valid", {31'h0, tx_valid_o}, 32'h0);

    // Overflow: fifth word dropped with error
    for (int i = 0; i < 5; i++) begin
      regAcc(1, 32'h00, 32'h11 + i, 4'hF, (i == 4), 0);
      if (i < 4) txQ.push_back(32'h11 + i);
    end
    regAcc(0, 32'h08, 0, 0, 0, 32'h0000_0049);
    regAcc(0, 32'h00, 0, 0, 1, 0);
    regAcc(1, 32'h08, 32'hFFFF_FFFF, 4'hF, 1, 0);
    regAcc(1, 32'h1C, 32'h1, 4'hF, 1, 0);
    regAcc(0, 32'h08, 0, 0, 0, 32'h0000_0049);
    tx_ready_i = 1'b1;
    tick(7);
    tx_ready_i = 1'b0;
    chk("tx_overflow_drained", {31'h0, tx_valid_o}, 32'h0);

    // Interrupt path
    regAcc(1, 32'h0C, 32'h1, 4'h1, 0, 0);
    regAcc(1, 32'h0C, 32'h0, 4'h0, 0, 0);
    regAcc(0, 32'h0C, 0, 0, 0, 32'h1);
    rxPushWord(32'h0000_00A5);
    chk("irq_same_cycle", {31'h0, irq_o}, 32'h0);
    tick(1);
    chk("irq_after_push", {31'h0, irq_o}, 32'h1);
    regAcc(0, 32'h10, 0, 0, 0, 32'h1);
    regAcc(0, 32'h04, 0, 0, 0, 32'h0000_00A5);
    regAcc(1, 32'h10, 32'h1, 4'h1, 0, 0);
    chk("irq_at_clear", {31'h0, irq_o}, 32'h1);
    tick(1);
    chk("irq_after_clear", {31'h0, irq_o}, 32'h0);
    regAcc(0, 32'h10, 0, 0, 0, 32'h0);
    rx_valid_i = 1'b1; rx_data_i = 32'h77;
    regAcc(1, 32'h10, 32'h1, 4'h1, 0, 0);
    rx_valid_i = 1'b0;
    regAcc(0, 32'h10, 0, 0, 0, 32'h1);
    regAcc(0, 32'h04, 0, 0, 0, 32'h77);
    regAcc(1, 32'h10, 32'h1, 4'h1, 0, 0);

    // RX full: simultaneous push and pop performs the pop only
    for (int i = 0; i < 4; i++) rxPushWord(32'hB0 + i);
    chk("rx_full_ready", {31'h0, rx_ready_o}, 32'h0);
    regAcc(0, 32'h08, 0, 0, 0, 32'h0000_0806);
    rx_valid_i = 1'b1; rx_data_i = 32'hBF;
    regAcc(0, 32'h04, 0, 0, 0, 32'hB0);
    rx_valid_i = 1'b0;
    chk("rx_ready_after_pop", {31'h0, rx_ready_o}, 32'h1);
    regAcc(0, 32'h08, 0, 0, 0, 32'h0000_0602);
    for (int i = 1; i < 4; i++) regAcc(0, 32'h04, 0, 0, 0, 32'hB0 + i);
    regAcc(0, 32'h04, 0, 0, 1, 0);
    regAcc(0, 32'h14, 0, 0, 1, 0);
    regAcc(0, 32'h08, 0, 0, 0, 32'h0000_000A);

    // Reset with both FIFOs holding two entries
    regAcc(1, 32'h00, 32'hDEAD0001, 4'hF, 0, 0);
    regAcc(1, 32'h00, 32'hDEAD0002, 4'hF, 0, 0);
    rxPushWord(32'hC1);
    rxPushWord(32'hC2);
    tick(2);
    chk("pre_rst_irq", {31'h0, irq_o}, 32'h1);
    rst_ni = 1'b0;
    #1;
    chk("mid_rst_tx_valid", {31'h0, tx_valid_o}, 32'h0);
    chk("mid_rst_rx_ready", {31'h0, rx_ready_o}, 32'h1);
    chk("mid_rst_irq", {31'h0, irq_o}, 32'h0);
    tick(2);
    rst_ni = 1'b1;
    tick(1);
    regAcc(0, 32'h08, 0, 0, 0, 32'h0000_000A);
    regAcc(0, 32'h0C, 0, 0, 0, 32'h0);
    regAcc(0, 32'h10, 0, 0, 0, 32'h0);
    regAcc(0, 32'h04, 0, 0, 1, 0);
    tx_ready_i = 1'b1;
    tick(3);
    tx_ready_i = 1'b0;
    chk("post_rst_tx_valid", {31'h0, tx_valid_o}, 32'h0);
    chk("post_rst_irq", {31'h0, irq_o}, 32'h0);

    tick(2);
    chk("reg_queue_left", regQ.size(), 32'h0);
    chk("tx_queue_left", txQ.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
